// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared widths, arbiter state type and requester encoding
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int STARVE_LIMIT_DEFAULT = 3;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  // bit positions inside the one-hot winner vector
  localparam int SEL_IFU = 0;
  localparam int SEL_ERD = 1;
  localparam int SEL_EWR = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select: starved IFU, then exec_wr > exec_rd > ifu_rd
module mem_arb_pick
  import pdp8_pkg::*;
(
  input  logic       wr_req,
  input  logic       erd_req,
  input  logic       ifu_req,
  input  logic       starve,
  output logic [2:0] winner
);

  always_comb begin
    winner = '0;
    if (ifu_req && starve) begin
      winner[SEL_IFU] = 1'b1;
    end else if (wr_req) begin
      winner[SEL_EWR] = 1'b1;
    end else if (erd_req) begin
      winner[SEL_ERD] = 1'b1;
    end else if (ifu_req) begin
      winner[SEL_IFU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester single-port memory arbiter with IFU starvation guard
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                   ifu_rd_gnt,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic                   ifu_rd_valid,
  input  logic                   exec_rd_req,
  input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                   exec_rd_gnt,
  output logic [`DATA_WIDTH-1:0] exec_rd_data,
  output logic                   exec_rd_valid,
  input  logic                   exec_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [`DATA_WIDTH-1:0] exec_wr_data,
  output logic                   exec_wr_gnt,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`DATA_WIDTH-1:0] mem_wdata,
  input  logic [`DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] STARVE_CMP = 2'(STARVE_LIMIT);

  arb_state_t             state, state_nxt;
  logic [2:0]             pick;
  logic [2:0]             sel_q, sel_nxt;
  logic [1:0]             starve_cnt, starve_cnt_nxt;
  logic                   starve;
  logic [2:0]             gnt_nxt;
  logic [1:0]             valid_nxt;
  logic                   mem_req_nxt, mem_we_nxt;
  logic [`ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [`DATA_WIDTH-1:0] mem_wdata_nxt;

  assign starve = (starve_cnt == STARVE_CMP);

  mem_arb_pick u_pick (
    .wr_req  (exec_wr_req),
    .erd_req (exec_rd_req),
    .ifu_req (ifu_rd_req),
    .starve  (starve),
    .winner  (pick)
  );

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel_q;
    starve_cnt_nxt = starve_cnt;
    gnt_nxt        = '0;
    valid_nxt      = '0;
    mem_req_nxt    = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    case (state)
      IDLE: begin
        if (|pick) begin
          state_nxt   = ISSUE;
          sel_nxt     = pick;
          gnt_nxt     = pick;
          mem_req_nxt = 1'b1;
          mem_we_nxt  = pick[SEL_EWR];
          if (pick[SEL_EWR]) begin
            mem_addr_nxt  = exec_wr_addr;
            mem_wdata_nxt = exec_wr_data;
          end else if (pick[SEL_ERD]) begin
            mem_addr_nxt  = exec_rd_addr;
            mem_wdata_nxt = '0;
          end else begin
            mem_addr_nxt  = ifu_rd_addr;
            mem_wdata_nxt = '0;
          end
          // IFU losses saturate so a large limit cannot wrap back to zero
          if (pick[SEL_IFU]) begin
            starve_cnt_nxt = '0;
          end else if (ifu_rd_req && starve_cnt != 2'b11) begin
            starve_cnt_nxt = starve_cnt + 2'd1;
          end
        end
      end
      ISSUE: begin
        state_nxt = sel_q[SEL_EWR] ? IDLE : RESP;
      end
      RESP: begin
        state_nxt = IDLE;
        valid_nxt = {sel_q[SEL_ERD], sel_q[SEL_IFU]};
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sel_q         <= '0;
      starve_cnt    <= '0;
      exec_wr_gnt   <= 1'b0;
      exec_rd_gnt   <= 1'b0;
      ifu_rd_gnt    <= 1'b0;
      exec_rd_valid <= 1'b0;
      ifu_rd_valid  <= 1'b0;
      ifu_rd_data   <= '0;
      exec_rd_data  <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      state         <= state_nxt;
      sel_q         <= sel_nxt;
      starve_cnt    <= starve_cnt_nxt;
      exec_wr_gnt   <= gnt_nxt[SEL_EWR];
      exec_rd_gnt   <= gnt_nxt[SEL_ERD];
      ifu_rd_gnt    <= gnt_nxt[SEL_IFU];
      exec_rd_valid <= valid_nxt[1];
      ifu_rd_valid  <= valid_nxt[0];
      mem_req       <= mem_req_nxt;
      mem_we        <= mem_we_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wdata     <= mem_wdata_nxt;
      if (valid_nxt[0]) ifu_rd_data <= mem_rdata;
      if (valid_nxt[1]) exec_rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table vectors, corner sequences and randomized run against a transaction model
module tb_mem_arbiter;

  localparam int AW = pdp8_pkg::ADDR_W;
  localparam int DW = pdp8_pkg::DATA_W;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [AW-1:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr;
  logic [DW-1:0] exec_wr_data, mem_rdata;
  logic          ifu_rd_gnt, exec_rd_gnt, exec_wr_gnt;
  logic [DW-1:0] ifu_rd_data, exec_rd_data;
  logic          ifu_rd_valid, exec_rd_valid;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ifu_rd_req    (ifu_rd_req),
    .ifu_rd_addr   (ifu_rd_addr),
    .ifu_rd_gnt    (ifu_rd_gnt),
    .ifu_rd_data   (ifu_rd_data),
    .ifu_rd_valid  (ifu_rd_valid),
    .exec_rd_req   (exec_rd_req),
    .exec_rd_addr  (exec_rd_addr),
    .exec_rd_gnt   (exec_rd_gnt),
    .exec_rd_data  (exec_rd_data),
    .exec_rd_valid (exec_rd_valid),
    .exec_wr_req   (exec_wr_req),
    .exec_wr_addr  (exec_wr_addr),
    .exec_wr_data  (exec_wr_data),
    .exec_wr_gnt   (exec_wr_gnt),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  // environment memory (reacts to what the DUT actually issues)
  logic [DW-1:0] env_mem [1 << AW];
  // reference model state: requester ids 2=exec_wr 1=exec_rd 0=ifu
  logic [DW-1:0] m_mem [1 << AW];
  int            m_next_arb;
  int            m_cnt;
  logic [DW-1:0] m_ifu, m_erd;
  // expectations per cycle, ring-indexed by cycle number
  logic [2:0]    e_gnt [16];
  logic          e_req [16];
  logic          e_we  [16];
  logic [AW-1:0] e_addr[16];
  logic [DW-1:0] e_wd  [16];
  logic [1:0]    e_val [16];
  logic [DW-1:0] e_vd  [16];
  // observed DUT activity for sequence-level checks
  int obs_gnt[$];
  int obs_we, obs_ifu_gnt, obs_erd_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_ring();
    for (int i = 0; i < 16; i++) begin
      e_gnt[i] = '0; e_req[i] = 1'b0; e_we[i] = 1'b0; e_addr[i] = '0;
      e_wd[i] = '0; e_val[i] = '0; e_vd[i] = '0;
    end
  endtask

  task automatic clear_obs();
    obs_gnt.delete();
    obs_we = 0; obs_ifu_gnt = 0; obs_erd_valid = 0;
  endtask

  // Transaction-level model: at each free arbitration edge pick a winner,
  // then schedule grant/issue for that cycle and read data two cycles later.
  task automatic model_sample(input int e);
    int w;
    int s;
    logic [AW-1:0] a;
    if (!reset_n || e < m_next_arb) return;
    if (!exec_wr_req && !exec_rd_req && !ifu_rd_req) return;
    if (ifu_rd_req && (m_cnt == LIMIT || (!exec_wr_req && !exec_rd_req))) w = 0;
    else if (exec_wr_req) w = 2;
    else w = 1;
    if (w == 0) m_cnt = 0;
    else if (ifu_rd_req) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
    s = e % 16;
    a = (w == 2) ? exec_wr_addr : (w == 1) ? exec_rd_addr : ifu_rd_addr;
    e_gnt[s]  = 3'(1 << w);
    e_req[s]  = 1'b1;
    e_we[s]   = (w == 2);
    e_addr[s] = a;
    e_wd[s]   = (w == 2) ? exec_wr_data : '0;
    if (w == 2) begin
      m_mem[a]   = exec_wr_data;
      m_next_arb = e + 2;
    end else begin
      e_val[(e + 2) % 16] = (w == 1) ? 2'b10 : 2'b01;
      e_vd[(e + 2) % 16]  = m_mem[a];
      m_next_arb = e + 3;
    end
  endtask

  task automatic check_cycle();
    int s;
    s = cyc % 16;
    if (e_val[s][0]) m_ifu = e_vd[s];
    if (e_val[s][1]) m_erd = e_vd[s];
    chk("gnt", {exec_wr_gnt, exec_rd_gnt, ifu_rd_gnt}, e_gnt[s]);
    chk("mem_req", mem_req, e_req[s]);
    chk("mem_we", mem_we, e_we[s]);
    if (e_req[s]) begin
      chk("mem_addr", mem_addr, e_addr[s]);
      chk("mem_wdata", mem_wdata, e_wd[s]);
    end
    chk("rd_valid", {exec_rd_valid, ifu_rd_valid}, e_val[s]);
    chk("ifu_rd_data", ifu_rd_data, m_ifu);
    chk("exec_rd_data", exec_rd_data, m_erd);
    if (exec_wr_gnt) obs_gnt.push_back(2);
    if (exec_rd_gnt) obs_gnt.push_back(1);
    if (ifu_rd_gnt) begin obs_gnt.push_back(0); obs_ifu_gnt++; end
    if (mem_we) obs_we++;
    if (exec_rd_valid) obs_erd_valid++;
    e_gnt[s] = '0; e_req[s] = 1'b0; e_we[s] = 1'b0; e_val[s] = '0;
  endtask

  task automatic tick();
    logic          rd_op, wr_op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_op = mem_req && !mem_we;
    wr_op = mem_req && mem_we;
    a = mem_addr;
    d = mem_wdata;
    model_sample(cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    if (wr_op) env_mem[a] = d;
    mem_rdata = rd_op ? env_mem[a] : DW'($urandom);
    check_cycle();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    ifu_rd_req = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0;
    clear_ring();
    m_cnt = 0; m_next_arb = 0; m_ifu = '0; m_erd = '0;
    #1;
    chk("reset_ctrl", {exec_wr_gnt, exec_rd_gnt, ifu_rd_gnt, exec_rd_valid, ifu_rd_valid, mem_req, mem_we}, 0);
    chk("reset_data", {ifu_rd_data, exec_rd_data, mem_addr, mem_wdata}, 0);
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    env_mem[a] = d;
    m_mem[a] = d;
  endtask

  task automatic drop_granted();
    if (exec_wr_gnt) exec_wr_req = 1'b0;
    if (exec_rd_gnt) exec_rd_req = 1'b0;
    if (ifu_rd_gnt) ifu_rd_req = 1'b0;
  endtask

  typedef struct {
    logic          wr, rd, ifu;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr, iaddr;
    logic [2:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl[7];
  int   seq_b[8];

  initial begin
    reset_n = 1'b0;
    ifu_rd_req = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0;
    ifu_rd_addr = '0; exec_rd_addr = '0; exec_wr_addr = '0;
    exec_wr_data = '0; mem_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = DW'(i * 37);
      m_mem[i]   = DW'(i * 37);
    end
    clear_obs();

    //         wr    rd    ifu   waddr    wdata    raddr    iaddr    gnt     we    addr     wd       rdata
    tbl[0] = '{1'b0, 1'b0, 1'b1, 12'o0010, 12'o1234, 12'o0033, 12'o0200, 3'b001, 1'b0, 12'o0200, 12'o0000, 12'o7402};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 12'o0010, 12'o1234, 12'o0033, 12'o0200, 3'b010, 1'b0, 12'o0033, 12'o0000, 12'o5252};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 12'o0010, 12'o1234, 12'o0033, 12'o0200, 3'b100, 1'b1, 12'o0010, 12'o1234, 12'o0000};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 12'o0011, 12'o4567, 12'o0033, 12'o0200, 3'b100, 1'b1, 12'o0011, 12'o4567, 12'o0000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 12'o0010, 12'o1234, 12'o0034, 12'o0201, 3'b010, 1'b0, 12'o0034, 12'o0000, 12'o5252};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 12'o0012, 12'o7070, 12'o0033, 12'o0200, 3'b100, 1'b1, 12'o0012, 12'o7070, 12'o0000};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 12'o0013, 12'o0707, 12'o0033, 12'o0202, 3'b100, 1'b1, 12'o0013, 12'o0707, 12'o0000};

    for (int i = 0; i < 7; i++) begin
      do_reset(2);
      preload(tbl[i].raddr, 12'o5252);
      preload(tbl[i].iaddr, 12'o7402);
      exec_wr_req = tbl[i].wr; exec_wr_addr = tbl[i].waddr; exec_wr_data = tbl[i].wdata;
      exec_rd_req = tbl[i].rd; exec_rd_addr = tbl[i].raddr;
      ifu_rd_req  = tbl[i].ifu; ifu_rd_addr = tbl[i].iaddr;
      tick();
      chk("tbl_gnt", {exec_wr_gnt, exec_rd_gnt, ifu_rd_gnt}, tbl[i].gnt);
      chk("tbl_we", {mem_req, mem_we}, {1'b1, tbl[i].we});
      chk("tbl_addr", mem_addr, tbl[i].addr);
      chk("tbl_wdata", mem_wdata, tbl[i].wd);
      exec_wr_req = 1'b0; exec_rd_req = 1'b0; ifu_rd_req = 1'b0;
      tick();
      tick();
      chk("tbl_valid", {exec_rd_valid, ifu_rd_valid}, tbl[i].gnt[1:0]);
      if (tbl[i].gnt[0]) chk("tbl_ifu_data", ifu_rd_data, tbl[i].rdata);
      if (tbl[i].gnt[1]) chk("tbl_exec_data", exec_rd_data, tbl[i].rdata);
    end

    // all three requesting at once: served in priority order, one write
    do_reset(1);
    clear_obs();
    exec_wr_req = 1'b1; exec_wr_addr = 12'o0010; exec_wr_data = 12'o1234;
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0020;
    ifu_rd_req  = 1'b1; ifu_rd_addr  = 12'o0030;
    repeat (10) begin tick(); drop_granted(); end
    chk("order_count", obs_gnt.size(), 3);
    if (obs_gnt.size() == 3) begin
      chk("order_0", obs_gnt[0], 2);
      chk("order_1", obs_gnt[1], 1);
      chk("order_2", obs_gnt[2], 0);
    end
    chk("order_we_count", obs_we, 1);

    // exec_rd held: IFU forced through every 4th arbitration
    do_reset(1);
    clear_obs();
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0100;
    ifu_rd_req  = 1'b1; ifu_rd_addr  = 12'o0200;
    repeat (30) begin
      tick();
      ifu_rd_req = !ifu_rd_gnt;
    end
    exec_rd_req = 1'b0; ifu_rd_req = 1'b0;
    repeat (3) tick();
    seq_b = '{1, 1, 1, 0, 1, 1, 1, 0};
    chk("starve_count_ok", obs_gnt.size() >= 8, 1);
    if (obs_gnt.size() >= 8)
      for (int i = 0; i < 8; i++) chk("starve_order", obs_gnt[i], seq_b[i]);

    // IFU request pulsed only during a write ISSUE is never granted
    do_reset(1);
    clear_obs();
    exec_wr_req = 1'b1; exec_wr_addr = 12'o0020; exec_wr_data = 12'o4321;
    tick();
    exec_wr_req = 1'b0;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0300;
    tick();
    ifu_rd_req = 1'b0;
    repeat (5) tick();
    chk("withdraw_no_gnt", obs_ifu_gnt, 0);

    // reset during RESP drops the read, next read is served normally
    do_reset(1);
    preload(12'o0040, 12'o1111);
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0040;
    tick();
    chk("rst_resp_gnt", exec_rd_gnt, 1);
    exec_rd_req = 1'b0;
    tick();
    do_reset(2);
    clear_obs();
    repeat (4) tick();
    chk("rst_resp_no_valid", obs_erd_valid, 0);
    chk("rst_resp_no_gnt", obs_gnt.size(), 0);
    preload(12'o0041, 12'o6543);
    exec_rd_req = 1'b1; exec_rd_addr = 12'o0041;
    tick();
    exec_rd_req = 1'b0;
    tick();
    tick();
    chk("rst_resp_next_valid", exec_rd_valid, 1);
    chk("rst_resp_next_data", exec_rd_data, 12'o6543);

    // write then read back through the environment memory
    do_reset(1);
    exec_wr_req = 1'b1; exec_wr_addr = 12'o7777; exec_wr_data = 12'o0055;
    tick();
    exec_wr_req = 1'b0;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o7777;
    tick();
    tick();
    chk("wr_rd_gnt", ifu_rd_gnt, 1);
    ifu_rd_req = 1'b0;
    tick();
    tick();
    chk("wr_rd_valid", ifu_rd_valid, 1);
    chk("wr_rd_data", ifu_rd_data, 12'o0055);

    // randomized traffic over a small address window
    do_reset(1);
    repeat (1500) begin
      tick();
      if (exec_wr_gnt) exec_wr_req = 1'b0;
      else if (exec_wr_req) begin
        if ($urandom_range(15) == 0) exec_wr_req = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        exec_wr_req = 1'b1;
        exec_wr_addr = AW'($urandom_range(15));
        exec_wr_data = DW'($urandom);
      end
      if (exec_rd_gnt) exec_rd_req = 1'b0;
      else if (exec_rd_req) begin
        if ($urandom_range(15) == 0) exec_rd_req = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        exec_rd_req = 1'b1;
        exec_rd_addr = AW'($urandom_range(15));
      end
      if (ifu_rd_gnt) ifu_rd_req = 1'b0;
      else if (ifu_rd_req) begin
        if ($urandom_range(15) == 0) ifu_rd_req = 1'b0;
      end else if ($urandom_range(1) == 0) begin
        ifu_rd_req = 1'b1;
        ifu_rd_addr = AW'($urandom_range(15));
      end
    end
    exec_wr_req = 1'b0; exec_rd_req = 1'b0; ifu_rd_req = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ifu_rd_req  in  1  IFU read request.
- ifu_rd_addr  in  `ADDR_WIDTH  IFU read address.
- ifu_rd_gnt  out  1  IFU grant pulse.
- ifu_rd_data  out  `DATA_WIDTH  IFU read data.
- ifu_rd_valid  out  1  IFU data-valid pulse.
- exec_rd_req, exec_rd_addr, exec_rd_gnt, exec_rd_data, exec_rd_valid  as IFU set  EXEC read channel.
- exec_wr_req  in  1  EXEC write request.
- exec_wr_addr  in  `ADDR_WIDTH  write address.
- exec_wr_data  in  `DATA_WIDTH  write data.
- exec_wr_gnt  out  1  write grant pulse.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  1 = write.
- mem_addr  out  `ADDR_WIDTH  memory address.
- mem_wdata  out  `DATA_WIDTH  write data.
- mem_rdata  in  `DATA_WIDTH  read data, valid the cycle after a read mem_req.

REQ-002 SHALL have one parameter: STARVE_LIMIT, default 3, the number of consecutive IFU losses before IFU is forced to win.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-004 SHALL sample requests only in IDLE; requests in ISSUE and RESP are ignored.
REQ-005 In IDLE with at least one request, SHALL select a winner and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-006 Base priority SHALL be exec_wr > exec_rd > ifu_rd.
REQ-007 SHALL keep a 2-bit starve counter:
- increments when ifu_rd_req is high in IDLE and IFU loses arbitration;
- clears when IFU is granted;
- holds otherwise.
REQ-008 When the starve counter equals STARVE_LIMIT, ifu_rd SHALL win over both EXEC requests.
REQ-009 ISSUE SHALL last exactly 1 cycle and SHALL assert the winner's gnt and mem_req for that cycle, with mem_addr, mem_we and mem_wdata registered from the winner.
- mem_wdata = 0 for reads.
REQ-010 From ISSUE, a write SHALL return to IDLE and a read SHALL go to RESP.
REQ-011 RESP SHALL last 1 cycle, register mem_rdata into the winner's rd_data, and pulse the winner's rd_valid for exactly the following cycle (IDLE).
REQ-012 Read timing: request sampled at edge N; gnt high in cycle N+1; rd_valid high in cycle N+3.
REQ-013 Repeat rate: back-to-back reads SHALL arbitrate every 3 cycles, writes every 2 cycles.
REQ-014 Arbitration SHALL proceed in the IDLE cycle in which rd_valid is high.
REQ-015 rd_data SHALL hold its last value when rd_valid is low; only the winner's rd_data SHALL change.
REQ-016 Requester rules:
- hold req, addr and wdata stable until gnt;
- drop req the cycle after gnt;
- withdrawing req before gnt is legal, and the arbiter SHALL then not grant it.
REQ-017 At most one gnt and at most one rd_valid SHALL be high in any cycle.
REQ-018 mem_req SHALL be high only in ISSUE, and mem_we SHALL be 0 whenever mem_req is 0.

Reset
REQ-019 On reset_n low, the FSM SHALL enter IDLE immediately, and the starve counter and all outputs (gnts, valids, rd_data, mem_*) SHALL be 0.
REQ-020 A reset asserted in ISSUE or RESP SHALL abort the transaction: no rd_valid is produced and no gnt is repeated after release.
REQ-021 Arbitration SHALL resume on the first rising clk edge after reset_n goes high.

Structure
REQ-022 pdp8_pkg SHALL hold the arb_state_t enum (IDLE, ISSUE, RESP) and a STARVE_LIMIT default constant; `ADDR_WIDTH and `DATA_WIDTH come from pdp8_pkg.
REQ-023 SHALL instantiate one combinational sub-module, mem_arb_pick: inputs are the three reqs and a starve flag; output is a one-hot winner. All state stays in mem_arbiter.

Verification
REQ-024 Single IFU read: ifu_rd_req with addr 12'o0200 and mem_rdata 12'o7402 -> ifu_rd_gnt in cycle N+1, mem_addr=12'o0200, mem_we=0, ifu_rd_valid in cycle N+3 with ifu_rd_data=12'o7402.
REQ-025 Simultaneous reqs: exec_wr addr 12'o0010 data 12'o1234, exec_rd, ifu_rd all high -> grant order exec_wr, exec_rd, ifu_rd; mem_we=1 only on the first ISSUE.
REQ-026 Starvation: exec_rd_req held high continuously, ifu_rd_req high -> IFU granted on the 4th arbitration, after 3 EXEC grants; counter then 0.
REQ-027 Withdrawal: ifu_rd_req high for 1 cycle while exec_wr is in ISSUE -> no ifu_rd_gnt ever issued.
REQ-028 Reset in RESP: reset_n low for 2 cycles during an exec read -> no exec_rd_valid, all outputs 0, next request served normally.
REQ-029 Write then read same address 12'o7777: exec write 12'o0055 followed by IFU read -> the model memory returns 12'o0055 on ifu_rd_data.
